// File: rtl/trace_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the trace command issuer.
package trace_pkg;

  localparam logic [3:0] READ              = 4'h0;
  localparam logic [3:0] WRITE             = 4'h1;
  localparam logic [3:0] INSTRUCTION_FETCH = 4'h2;
  localparam logic [3:0] INVALIDATE        = 4'h3;
  localparam logic [3:0] SNOOP             = 4'h4;
  localparam logic [3:0] RESET             = 4'h8;
  localparam logic [3:0] PRINT             = 4'h9;
  localparam logic [3:0] NOP               = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  function automatic logic is_valid_opcode(logic [3:0] op);
    case (op)
      READ, WRITE, INSTRUCTION_FETCH, INVALIDATE, SNOOP, RESET, PRINT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_cmd_issuer_if.sv
// Loader-side entry handshake plus cache-side command bus of the trace command issuer.
interface trace_cmd_issuer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_command;
  logic [ADDR_W-1:0] in_address;
  logic              in_last;
  logic              cache_ready;
  logic [3:0]        command;
  logic [ADDR_W-1:0] address;
  logic              cmd_valid;
  logic              mode;
  logic              done;

  modport master (
    input  in_valid, in_command, in_address, in_last, cache_ready,
    output in_ready, command, address, cmd_valid, mode, done
  );

  modport slave (
    output in_valid, in_command, in_address, in_last, cache_ready,
    input  in_ready, command, address, cmd_valid, mode, done
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap freely.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/trace_cmd_issuer.sv
// Buffers trace entries and issues one registered command per cycle to the cache model.
// Optional TRACE_FILTER_EN: drop invalid opcodes and count them in skipped_count.
module trace_cmd_issuer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode_in,
  trace_cmd_issuer_if.master  bus,
  output logic [31:0]         issued_count,
  output logic [31:0]         skipped_count
);

  localparam int unsigned EntryW = ADDR_W + 5;
  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);

  state_e              state_q, state_d;
  logic [FlushW-1:0]   flush_cnt_q, flush_cnt_d;
  logic                mode_q, mode_d;
  logic [3:0]          command_q, command_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [31:0]         issued_q, issued_d;
  logic [31:0]         skipped_q, skipped_d;

  logic                fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0]   fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                unused_count;
  logic                entry_last, issue;
  logic [3:0]          entry_cmd;
  logic [ADDR_W-1:0]   entry_addr;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .wdata ({bus.in_last, bus.in_command, bus.in_address}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_count = ^fifo_count;
  assign entry_last   = fifo_rdata[EntryW-1];
  assign entry_cmd    = fifo_rdata[ADDR_W +: 4];
  assign entry_addr   = fifo_rdata[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    mode_d      = mode_q;
    command_d   = NOP;
    address_d   = '0;
    cmd_valid_d = 1'b0;
    issued_d    = issued_q;
    skipped_d   = skipped_q;
    fifo_pop    = 1'b0;
    issue       = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d    = mode_in;
          issued_d  = '0;
          skipped_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!fifo_empty && bus.cache_ready) begin
          fifo_pop = 1'b1;
          issue    = 1'b1;
`ifdef TRACE_FILTER_EN
          issue = is_valid_opcode(entry_cmd);
          if (!issue) skipped_d = sat_inc(skipped_q);
`endif
          if (issue) begin
            command_d   = entry_cmd;
            address_d   = entry_addr;
            cmd_valid_d = 1'b1;
            issued_d    = sat_inc(issued_q);
          end
          // The last entry's own issue cycle is FLUSH cycle zero, so NOPs follow it.
          if (entry_last) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FlushW'(FLUSH_CYCLES)) state_d = DONE;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      mode_q      <= 1'b0;
      command_q   <= NOP;
      address_q   <= '0;
      cmd_valid_q <= 1'b0;
      issued_q    <= '0;
      skipped_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mode_q      <= mode_d;
      command_q   <= command_d;
      address_q   <= address_d;
      cmd_valid_q <= cmd_valid_d;
      issued_q    <= issued_d;
      skipped_q   <= skipped_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.command   = command_q;
  assign bus.address   = address_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.mode      = mode_q;
  assign bus.done      = (state_q == DONE);
  assign issued_count  = issued_q;
  assign skipped_count = skipped_q;

endmodule

// File: tb/tb_trace_cmd_issuer.sv
// Self-checking bench for trace_cmd_issuer: directed scenarios plus randomized streams
// checked against an in-order expected-issue queue derived from the opcode rules.
module tb_trace_cmd_issuer;

  localparam int unsigned Depth       = 16;
  localparam int unsigned AddrW       = 32;
  localparam int unsigned FlushCycles = 4;
  localparam logic [3:0]  NopCode     = 4'hF;
`ifdef TRACE_FILTER_EN
  localparam bit FilterEn = 1'b1;
`else
  localparam bit FilterEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode_in = 1'b0;
  logic [31:0] issued_count, skipped_count;

  trace_cmd_issuer_if #(.ADDR_W(AddrW)) bus ();

  trace_cmd_issuer #(
    .DEPTH        (Depth),
    .ADDR_W       (AddrW),
    .FLUSH_CYCLES (FlushCycles)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode_in       (mode_in),
    .bus           (bus),
    .issued_count  (issued_count),
    .skipped_count (skipped_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  st_cmd[$];
  logic [31:0] st_addr[$];
  bit          st_last[$];
  logic [3:0]  valid_ops[7];

  function automatic bit spec_valid(logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_command  = 4'h0;
    bus.in_address  = '0;
    bus.in_last     = 1'b0;
    bus.cache_ready = 1'b0;
    start           = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_stim();
    st_cmd.delete();
    st_addr.delete();
    st_last.delete();
  endtask

  task automatic add_stim(input logic [3:0] c, input logic [31:0] a, input bit l);
    st_cmd.push_back(c);
    st_addr.push_back(a);
    st_last.push_back(l);
  endtask

  task automatic push_one(input logic [3:0] c, input logic [31:0] a, input bit l, input string name);
    bus.in_valid   = 1'b1;
    bus.in_command = c;
    bus.in_address = a;
    bus.in_last    = l;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s push: in_ready=%b required 1", name, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    logic [103:0] got, exp;
    got = {bus.command, bus.address, bus.cmd_valid, bus.mode, bus.done, bus.in_ready,
           issued_count, skipped_count};
    exp = {NopCode, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs=%h required %h", name, got, exp);
    end
  endtask

  // Pre-pushes n_pre stimulus entries, starts a run, streams the rest while randomly stalling,
  // and checks issue order, stall behaviour, flush length and final counters.
  task automatic run_stream(input string name, input int n_pre, input int ready_pct,
                            input int push_pct, input bit mode_val, input int exp_first);
    logic [3:0]  ecmd[$];
    logic [31:0] eaddr[$];
    int n, exp_iss, exp_skp, idx, cyc, first_cyc, last_cyc, nops;
    bit seen_done, rdy, acc;
    n = st_cmd.size();
    exp_iss = 0; exp_skp = 0; idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1; nops = 0;
    seen_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!FilterEn || spec_valid(st_cmd[i])) begin
        ecmd.push_back(st_cmd[i]);
        eaddr.push_back(st_addr[i]);
        exp_iss++;
      end else begin
        exp_skp++;
      end
    end
    while (idx < n_pre) begin
      push_one(st_cmd[idx], st_addr[idx], st_last[idx], name);
      idx++;
    end
    mode_in = mode_val;
    start = 1'b1;
    bus.cache_ready = 1'b0;
    tick();
    start = 1'b0;
    while (!seen_done && cyc < 2000) begin
      rdy = ($urandom_range(99) < ready_pct);
      bus.cache_ready = rdy;
      acc = 1'b0;
      if (idx < n && $urandom_range(99) < push_pct) begin
        bus.in_valid   = 1'b1;
        bus.in_command = st_cmd[idx];
        bus.in_address = st_addr[idx];
        bus.in_last    = st_last[idx];
        acc = bus.in_ready;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      cyc++;
      if (acc) idx++;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.cmd_valid === 1'b1) begin
        if (!rdy) begin
          errors++;
          $display("FAIL %s stall: cmd_valid=1 at cycle %0d required 0 after cache_ready=0",
                   name, cyc);
        end else if (ecmd.size() == 0) begin
          errors++;
          $display("FAIL %s extra: command=%h address=%h required no issue",
                   name, bus.command, bus.address);
        end else if ({bus.command, bus.address} !== {ecmd[0], eaddr[0]}) begin
          errors++;
          $display("FAIL %s issue: command=%h address=%h required command=%h address=%h",
                   name, bus.command, bus.address, ecmd[0], eaddr[0]);
        end
        if (ecmd.size() != 0) begin
          void'(ecmd.pop_front());
          void'(eaddr.pop_front());
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nops = 0;
      end else begin
        if (bus.command !== NopCode) begin
          errors++;
          $display("FAIL %s nop: command=%h required %h while cmd_valid=0",
                   name, bus.command, NopCode);
        end
        if (bus.done === 1'b1) seen_done = 1'b1;
        else nops++;
      end
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s timeout: done=%b required 1 within 2000 cycles", name, bus.done);
    end
    checks++;
    if (ecmd.size() != 0) begin
      errors++;
      $display("FAIL %s missing: %0d commands not issued required 0", name, ecmd.size());
    end
    checks++;
    if (nops != FlushCycles) begin
      errors++;
      $display("FAIL %s flush: %0d NOP cycles before done required %0d", name, nops, FlushCycles);
    end
    checks++;
    if ({issued_count, skipped_count} !== {32'(exp_iss), 32'(exp_skp)}) begin
      errors++;
      $display("FAIL %s counters: issued=%0d skipped=%0d required issued=%0d skipped=%0d",
               name, issued_count, skipped_count, exp_iss, exp_skp);
    end
    checks++;
    if (bus.mode !== mode_val) begin
      errors++;
      $display("FAIL %s mode: mode=%b required %b", name, bus.mode, mode_val);
    end
    if (exp_first >= 0) begin
      checks++;
      if (first_cyc != exp_first || (last_cyc - first_cyc + 1) != exp_iss) begin
        errors++;
        $display("FAIL %s timing: first=%0d last=%0d required first=%0d last=%0d",
                 name, first_cyc, last_cyc, exp_first, exp_first + exp_iss - 1);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    apply_reset();
    clear_stim();
    add_stim(4'h2, 32'h100, 1'b0);
    add_stim(4'h0, 32'h200, 1'b0);
    add_stim(4'h1, 32'h300, 1'b1);
    run_stream("basic", 3, 100, 100, 1'b0, 1);
  endtask

  task automatic test_stall();
    logic [31:0] a0, a1;
    int waited;
    bit extra;
    apply_reset();
    a0 = $urandom;
    a1 = $urandom;
    push_one(4'h3, a0, 1'b0, "stall");
    push_one(4'h8, a1, 1'b1, "stall");
    mode_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cache_ready = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_valid, bus.command, bus.address} !== {1'b1, 4'h3, a0}) begin
      errors++;
      $display("FAIL stall first: valid=%b command=%h address=%h required 1 3 %h",
               bus.cmd_valid, bus.command, bus.address, a0);
    end
    bus.cache_ready = 1'b0;
    tick();
    checks++;
    if ({bus.cmd_valid, bus.command} !== {1'b0, NopCode}) begin
      errors++;
      $display("FAIL stall hold: valid=%b command=%h required 0 f", bus.cmd_valid, bus.command);
    end
    bus.cache_ready = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_valid, bus.command, bus.address} !== {1'b1, 4'h8, a1}) begin
      errors++;
      $display("FAIL stall second: valid=%b command=%h address=%h required 1 8 %h",
               bus.cmd_valid, bus.command, bus.address, a1);
    end
    waited = 0;
    extra = 1'b0;
    while (bus.done !== 1'b1 && waited < 20) begin
      tick();
      waited++;
      if (bus.cmd_valid === 1'b1) extra = 1'b1;
    end
    checks++;
    if (bus.done !== 1'b1 || extra || issued_count !== 32'd2) begin
      errors++;
      $display("FAIL stall end: done=%b reissue=%b issued=%0d required done=1 reissue=0 issued=2",
               bus.done, extra, issued_count);
    end
  endtask

  task automatic test_full();
    logic [3:0]  ecmd[$];
    logic [31:0] eaddr[$];
    logic [3:0]  c;
    logic [31:0] a;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      c = valid_ops[i % 7];
      a = $urandom;
      ecmd.push_back(c);
      eaddr.push_back(a);
      push_one(c, a, 1'b0, "full");
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full ready: in_ready=%b required 0 with 16 entries", bus.in_ready);
    end
    // A 17th entry marked last: accepting it would make the run finish.
    bus.in_valid   = 1'b1;
    bus.in_command = 4'h9;
    bus.in_address = 32'hDEAD_BEEF;
    bus.in_last    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    mode_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.cache_ready = 1'b1;
      tick();
      if (cyc == 0) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL full reopen: in_ready=%b required 1 after one pop", bus.in_ready);
        end
      end
      if (bus.cmd_valid === 1'b1) begin
        checks++;
        if (ecmd.size() == 0) begin
          errors++;
          $display("FAIL full extra: command=%h address=%h required no issue",
                   bus.command, bus.address);
        end else begin
          if ({bus.command, bus.address} !== {ecmd[0], eaddr[0]}) begin
            errors++;
            $display("FAIL full issue: command=%h address=%h required command=%h address=%h",
                     bus.command, bus.address, ecmd[0], eaddr[0]);
          end
          void'(ecmd.pop_front());
          void'(eaddr.pop_front());
        end
      end
    end
    checks++;
    if (ecmd.size() != 0 || issued_count !== 32'd16 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL full end: left=%0d issued=%0d done=%b required left=0 issued=16 done=0",
               ecmd.size(), issued_count, bus.done);
    end
  endtask

  task automatic test_filter();
    apply_reset();
    clear_stim();
    add_stim(4'h5, 32'h10, 1'b0);
    add_stim(4'h0, 32'h20, 1'b1);
    run_stream("filter", 2, 100, 100, 1'b0, -1);
  endtask

  task automatic test_reset_midrun();
    int seen;
    apply_reset();
    for (int i = 0; i < 5; i++) push_one(valid_ops[i], $urandom, 1'b0, "midrun");
    mode_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.cache_ready = 1'b1;
    tick();
    bus.cache_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_async");
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midrun_release");
    mode_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bus.cache_ready = 1'b1;
      tick();
      if (bus.cmd_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || issued_count !== 32'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun empty: issues=%0d issued=%0d in_ready=%b required 0 0 1",
               seen, issued_count, bus.in_ready);
    end
  endtask

  task automatic test_done_restart();
    logic [31:0] a0;
    int waited;
    apply_reset();
    clear_stim();
    add_stim(valid_ops[$urandom_range(6)], $urandom, 1'b0);
    add_stim(valid_ops[$urandom_range(6)], $urandom, 1'b0);
    add_stim(valid_ops[$urandom_range(6)], $urandom, 1'b1);
    run_stream("restart_first", 3, 100, 100, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.done, bus.cmd_valid, bus.command} !== {1'b1, 1'b0, NopCode}) begin
        errors++;
        $display("FAIL done hold: done=%b valid=%b command=%h required 1 0 f",
                 bus.done, bus.cmd_valid, bus.command);
      end
    end
    a0 = $urandom;
    push_one(4'h4, a0, 1'b0, "restart");
    push_one(4'h9, $urandom, 1'b1, "restart");
    mode_in = 1'b1;
    start = 1'b1;
    bus.cache_ready = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if ({bus.done, bus.mode, issued_count, skipped_count} !== {1'b0, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL restart: done=%b mode=%b issued=%0d skipped=%0d required 0 1 0 0",
               bus.done, bus.mode, issued_count, skipped_count);
    end
    bus.cache_ready = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_valid, bus.command, bus.address} !== {1'b1, 4'h4, a0}) begin
      errors++;
      $display("FAIL restart issue: valid=%b command=%h address=%h required 1 4 %h",
               bus.cmd_valid, bus.command, bus.address, a0);
    end
    waited = 0;
    while (bus.done !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.done !== 1'b1 || issued_count !== 32'd2) begin
      errors++;
      $display("FAIL restart end: done=%b issued=%0d required done=1 issued=2",
               bus.done, issued_count);
    end
  endtask

  task automatic test_random();
    int n, n_pre;
    apply_reset();
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      n = $urandom_range(24, 1);
      for (int i = 0; i < n; i++) begin
        if (i == n - 1) add_stim(valid_ops[$urandom_range(6)], $urandom, 1'b1);
        else add_stim(4'($urandom_range(15)), $urandom, 1'b0);
      end
      n_pre = $urandom_range((n < 16) ? n : 16, 0);
      run_stream("random", n_pre, $urandom_range(100, 30), $urandom_range(100, 40),
                 1'($urandom_range(1)), -1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_ops[0] = 4'h0;
    valid_ops[1] = 4'h1;
    valid_ops[2] = 4'h2;
    valid_ops[3] = 4'h3;
    valid_ops[4] = 4'h4;
    valid_ops[5] = 4'h8;
    valid_ops[6] = 4'h9;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_filter();
    test_reset_midrun();
    test_done_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_cmd_issuer.md
Name: trace_cmd_issuer

Overview:
- Producer end of the trace-command interface: buffers decoded trace entries and drives command/address/mode/done into the cache simulation top, one command per cycle.
- Sits between the trace loader (testbench or file-reader front end) and the cache simulation top.
- Handles flow control, invalid-code filtering, end-of-trace flush, and the done pulse that triggers the statistics print.

Parameters:
- DEPTH, 16, entry FIFO depth; must be a power of 2 and at least 2.
- ADDR_W, 32, address width; matches AddressBits.
- FLUSH_CYCLES, 4, NOP cycles issued after the last command before done asserts; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a trace run; mode_in is latched on this pulse.
- mode_in  in  1  run mode to latch.
- in_valid  in  1  loader entry valid.
- in_ready  out  1  FIFO can accept an entry (not full).
- in_command  in  4  trace opcode.
- in_address  in  ADDR_W  trace address.
- in_last  in  1  marks the final trace entry.
- cache_ready  in  1  consumer can take a command this cycle.
- command  out  4  opcode to cache; NOP=4'hF when idle.
- address  out  ADDR_W  address to cache.
- cmd_valid  out  1  command/address are a real issue this cycle.
- mode  out  1  latched mode.
- done  out  1  end of trace; sticky.
- issued_count  out  32  commands issued in this run.
- skipped_count  out  32  invalid codes dropped; see optional feature.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied; state IDLE; command=4'hF; address=0; cmd_valid=0; mode=0; done=0; both counters=0; in_ready=1.
- Valid opcodes: 0, 1, 2, 3, 4, 8, 9. All other codes are invalid.
- Push: occurs when in_valid && in_ready. in_ready = !full, registered from occupancy. There is no combinational bypass: a pushed entry is poppable the next cycle at the earliest.
- FSM states:
  - IDLE: outputs NOP. On start: latch mode, clear counters, go to RUN.
  - RUN: when FIFO is non-empty and cache_ready=1, pop one entry.
    - On the next cycle, command/address/cmd_valid=1 are registered outputs (1-cycle latency), and issued_count increments.
    - If cache_ready=0 or the FIFO is empty, drive NOP with cmd_valid=0 next cycle. Nothing is reissued or duplicated.
    - If the popped entry has in_last=1: go to FLUSH after it issues.
    - start is ignored while in RUN.
  - FLUSH: drive NOP for exactly FLUSH_CYCLES cycles (counter), then go to DONE. Pushes are still accepted but not popped.
  - DONE: done=1, held; outputs NOP. On start: done=0, counters cleared, mode re-latched, go to RUN. Remaining FIFO entries are kept.
- RESET (8) and PRINT (9) opcodes are issued like any other command; the block does not interpret them.
- Simultaneous push and pop: both occur in the same cycle and occupancy is unchanged. Pointers wrap modulo DEPTH.
- Counters saturate at 32'hFFFFFFFF.
- Reset mid-run: immediate return to the reset state. Any in-flight output is dropped.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined: an invalid opcode is popped but not issued. skipped_count increments, and the next cycle is NOP with cmd_valid=0. An invalid entry with in_last=1 still triggers FLUSH.
- Undefined: every opcode is issued unchanged, and skipped_count is tied to 0.

Decomposition:
- Shared package trace_pkg holds:
  - opcode localparams READ=0, WRITE=1, INSTRUCTION_FETCH=2, INVALIDATE=3, SNOOP=4, RESET=8, PRINT=9, NOP=4'hF;
  - the FSM state encoding (IDLE, RUN, FLUSH, DONE);
  - an is_valid_opcode function.
- One sub-module, trace_fifo: a synchronous FIFO with parameterised DEPTH/width, full/empty/count, asynchronous active-low reset.

Test Plan:
- Push {2,0x100},{0,0x200},{1,0x300,last}, then pulse start with cache_ready=1 → command sequence 2, 0, 1 on consecutive cycles with cmd_valid=1; then 4 NOP cycles; then done=1; issued_count=3.
- cache_ready toggles 1,0,1 during RUN with 2 entries queued → each command issues exactly once, with a NOP/cmd_valid=0 cycle for the stalled cycle; issued_count=2.
- Push 16 entries with no start (DEPTH=16) → in_ready=0; the 17th push is not accepted. After start and one pop, in_ready returns to 1.
- TRACE_FILTER_EN: entries {5,0x10},{0,0x20,last} → only READ 0x20 is issued; skipped_count=1, issued_count=1, done asserts. With the macro undefined, command 5 is issued and skipped_count=0.
- rst_n low for 1 cycle mid-RUN with 5 entries queued → all outputs return to reset values, FIFO is empty, and done=0.
- In DONE, pulse start with mode_in=1 → done clears, mode=1, counters are 0, and the FSM is back in RUN.
